// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default latencies and small op-decode helpers.
package mul_div_unit_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 8;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_arith(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// EX-stage <-> multiply/divide unit signal bundle.
interface mul_div_unit_if;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] md_out;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output md_op, A, B, input start, busy, md_out, HI, LO);
    modport slave  (input md_op, A, B, output start, busy, md_out, HI, LO);
endinterface

// File: rtl/mul_div_unit_calc.sv
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu plus a
// divide-by-zero flag; the divider sees a safe divisor when B is zero.
module mul_div_unit_calc
    import mul_div_unit_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_result,
    output logic        o_div_zero
);

    logic        w_a_neg, w_b_neg, w_b_zero;
    logic [31:0] w_a_mag, w_b_mag;
    logic [31:0] w_div_s, w_div_u;
    logic [31:0] w_qs_mag, w_rs_mag;
    logic [31:0] w_q_s, w_r_s;
    logic [31:0] w_q_u, w_r_u;
    logic [63:0] w_prod_s, w_prod_u;

    assign w_a_neg  = i_a[31];
    assign w_b_neg  = i_b[31];
    assign w_b_zero = (i_b == 32'd0);

    // Signed divide goes through magnitudes so truncation is toward zero and
    // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
    assign w_a_mag  = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag  = w_b_neg ? (32'd0 - i_b) : i_b;
    assign w_div_s  = w_b_zero ? 32'd1 : w_b_mag;
    assign w_div_u  = w_b_zero ? 32'd1 : i_b;

    assign w_qs_mag = w_a_mag / w_div_s;
    assign w_rs_mag = w_a_mag % w_div_s;
    assign w_q_s    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_qs_mag) : w_qs_mag;
    assign w_r_s    = w_a_neg ? (32'd0 - w_rs_mag) : w_rs_mag;

    assign w_q_u    = i_a / w_div_u;
    assign w_r_u    = i_a % w_div_u;

    assign w_prod_s = {{32{w_a_neg}}, i_a} * {{32{w_b_neg}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    always_comb begin
        o_result = 64'd0;
        case (i_op)
            MD_MULT:  o_result = w_prod_s;
            MD_MULTU: o_result = w_prod_u;
            MD_DIV:   o_result = {w_r_s, w_q_s};
            MD_DIVU:  o_result = {w_r_u, w_q_u};
            default:  o_result = 64'd0;
        endcase
    end

    assign o_div_zero = w_b_zero && is_div(i_op);

endmodule

// File: rtl/mul_div_unit.sv
// Multiply/divide unit owning HI/LO: a fixed-latency busy window per op,
// result computed at start and held pending until the window ends.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave md
);

    md_state_e          r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic [31:0]        r_hi, r_lo;
    logic [63:0]        r_pend;

    logic               w_start;
    logic [63:0]        w_result;
    logic               w_div_zero;

    mul_div_unit_calc u_calc (
        .i_op       (md.md_op),
        .i_a        (md.A),
        .i_b        (md.B),
        .o_result   (w_result),
        .o_div_zero (w_div_zero)
    );

    assign w_start = is_arith(md.md_op) && !r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_pend  <= 64'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        // Divide by zero commits the current HI/LO back, leaving them unchanged.
                        r_pend  <= w_div_zero ? {r_hi, r_lo} : w_result;
                        r_count <= is_div(md.md_op) ? CNT_W'(DIV_CYCLES - 1)
                                                    : CNT_W'(MULT_CYCLES - 1);
                        r_busy  <= 1'b1;
                        r_state <= ST_BUSY;
                    end else if (md.md_op == MD_MTHI) begin
                        r_hi <= md.A;
                    end else if (md.md_op == MD_MTLO) begin
                        r_lo <= md.A;
                    end
                end
                ST_BUSY: begin
                    if (r_count == '0) begin
                        r_hi    <= r_pend[63:32];
                        r_lo    <= r_pend[31:0];
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        md.md_out = 32'd0;
        if (md.md_op == MD_MFHI)      md.md_out = r_hi;
        else if (md.md_op == MD_MFLO) md.md_out = r_lo;
    end

    assign md.start = w_start;
    assign md.busy  = r_busy;
    assign md.HI    = r_hi;
    assign md.LO    = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed + randomized checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mul_div_unit_if bus ();

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, then let comb outputs settle.
    task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.md_op = op;
        bus.A     = a;
        bus.B     = b;
        #1;
    endtask

    // Architectural reference: new {HI,LO} after op on a,b given current model state.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        int     sa, sb;
        longint p;
        sa = int'(a);
        sb = int'(b);
        hi = m_hi;
        lo = m_lo;
        case (op)
            4'd1: begin p = longint'(sa) * longint'(sb); {hi, lo} = p; end
            4'd2: {hi, lo} = {32'd0, a} * {32'd0, b};
            4'd3: if (b != 32'd0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 32'd0;
                end else begin
                    lo = sa / sb; hi = sa % sb;
                end
            end
            4'd4: if (b != 32'd0) begin lo = a / b; hi = a % b; end
            default: ;
        endcase
    endfunction

    // Issue an arithmetic op, drive busy_op on every busy cycle, check the busy
    // window length, pre-op HI/LO visibility and the commit.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] busy_op);
        logic [31:0] eh, el;
        int n;
        model(op, a, b, eh, el);
        n = (op == 4'd3 || op == 4'd4) ? 10 : 5;
        cyc(op, a, b);
        chk({tag, ".start"}, {31'd0, bus.start}, 32'd1);
        chk({tag, ".busy0"}, {31'd0, bus.busy}, 32'd0);
        for (int i = 1; i <= n; i++) begin
            cyc(busy_op, $urandom, $urandom);
            chk({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
            chk({tag, ".nostart"}, {31'd0, bus.start}, 32'd0);
            chk({tag, ".hi_pre"}, bus.HI, m_hi);
            chk({tag, ".lo_pre"}, bus.LO, m_lo);
            if (busy_op == 4'd7) chk({tag, ".mfhi_pre"}, bus.md_out, m_hi);
        end
        cyc(4'd0, 32'd0, 32'd0);
        chk({tag, ".busy_end"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, ".hi"}, bus.HI, eh);
        chk({tag, ".lo"}, bus.LO, el);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        bus.md_op = 4'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst.hi", bus.HI, 32'd0);
        chk("rst.lo", bus.LO, 32'd0);
        chk("rst.busy", {31'd0, bus.busy}, 32'd0);
        chk("rst.start", {31'd0, bus.start}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed arithmetic
        run_op("mult_m1x2", 4'd1, 32'hFFFF_FFFF, 32'd2, 4'd0);
        chk("mult_m1x2.hi_const", bus.HI, 32'hFFFF_FFFF);
        chk("mult_m1x2.lo_const", bus.LO, 32'hFFFF_FFFE);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 4'd7);
        chk("multu.hi_const", bus.HI, 32'h0000_0001);
        run_op("div_m7_2", 4'd3, 32'hFFFF_FFF9, 32'd2, 4'd0);
        chk("div.lo_const", bus.LO, 32'hFFFF_FFFD);
        chk("div.hi_const", bus.HI, 32'hFFFF_FFFF);
        cyc(4'd5, 32'd1, 32'd0);
        cyc(4'd6, 32'd2, 32'd0);
        m_hi = 32'd1; m_lo = 32'd2;
        run_op("divu_by0", 4'd4, 32'd7, 32'd0, 4'd0);
        chk("divu_by0.hi_const", bus.HI, 32'd1);
        chk("divu_by0.lo_const", bus.LO, 32'd2);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'd0);
        run_op("div_by0", 4'd3, 32'h1234_5678, 32'd0, 4'd0);

        // mthi/mtlo and mfhi/mflo
        cyc(4'd6, 32'd0, 32'd0);
        cyc(4'd5, 32'h1234_5678, 32'd0);
        m_lo = 32'd0; m_hi = 32'h1234_5678;
        cyc(4'd8, 32'd0, 32'd0);
        chk("mflo", bus.md_out, 32'd0);
        cyc(4'd7, 32'd0, 32'd0);
        chk("mfhi", bus.md_out, 32'h1234_5678);
        cyc(4'd0, 32'd0, 32'd0);
        chk("none.md_out", bus.md_out, 32'd0);
        cyc(4'd12, 32'hFFFF_FFFF, 32'd3);
        chk("undef.md_out", bus.md_out, 32'd0);
        chk("undef.start", {31'd0, bus.start}, 32'd0);
        run_op("mtlo_busy", 4'd1, 32'd3, 32'd5, 4'd6);
        run_op("mthi_busy", 4'd4, 32'd100, 32'd7, 4'd5);

        // div issued while mult in flight is ignored
        run_op("div_in_mult", 4'd1, 32'h0001_0000, 32'h0003_0000, 4'd3);

        // Reset mid-operation aborts without commit
        cyc(4'd1, 32'd7, 32'd9);
        cyc(4'd0, 32'd0, 32'd0);
        chk("abort.busy_t1", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("abort.busy_t2", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort.busy", {31'd0, bus.busy}, 32'd0);
        chk("abort.hi", bus.HI, 32'd0);
        chk("abort.lo", bus.LO, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (7) cyc(4'd0, 32'd0, 32'd0);
        chk("abort.nocommit_hi", bus.HI, 32'd0);
        chk("abort.nocommit_lo", bus.LO, 32'd0);
        chk("abort.idle", {31'd0, bus.busy}, 32'd0);

        // Randomized ops
        for (int k = 0; k < 30; k++) begin
            op = 4'($urandom_range(1, 4));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            run_op("rand", op, a, b, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom;
                cyc(4'd5, a, 32'd0);
                m_hi = a;
                cyc(4'd7, 32'd0, 32'd0);
                chk("rand.mfhi", bus.md_out, m_hi);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
